// File: rtl/vx_mem_arb_pkg.sv
// Shared helpers and request bundle for the multi-channel memory arbiter.
// Tag widths grow by the requester index bits appended on the way out.
package vx_mem_arb_pkg;

  function automatic int calc_req_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_tag_out_width(input int tag_in, input int n);
    return tag_in + calc_req_bits(n);
  endfunction

  // Request bundle at the default cluster configuration
  typedef struct packed {
    logic         rw;
    logic [63:0]  byteen;
    logic [5:0]   size;
    logic [31:0]  addr;
    logic [511:0] data;
    logic [9:0]   tag;
  } mem_req_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin picker: searches from the pointer, moves past the winner
// only when the caller reports that the grant was consumed.
module vx_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic                  fire,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_INPUTS);
      if (!grant_valid && valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant = grant_valid ? (NUM_INPUTS'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (fire && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                  : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_mem_channel_arb.sv
// Routes requester ports onto address-interleaved memory channels and
// steers responses back by the requester index carried in the tag.
module vx_mem_channel_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int SIZE_WIDTH   = 6,
  parameter int TAG_IN_WIDTH = 8,
  parameter int CH_SEL_LSB   = 6,
  parameter int MAX_PENDING  = 16,
  localparam int REQ_BITS      = calc_req_bits(NUM_REQS),
  localparam int TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int BE_W          = DATA_WIDTH / 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQS-1:0]                        req_valid_in,
  input  logic [NUM_REQS-1:0]                        req_rw_in,
  input  logic [NUM_REQS-1:0][BE_W-1:0]              req_byteen_in,
  input  logic [NUM_REQS-1:0][SIZE_WIDTH-1:0]        req_size_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]        req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]        req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]      req_tag_in,
  output logic [NUM_REQS-1:0]                        req_ready_in,
  output logic [NUM_CHANNELS-1:0]                    mem_req_valid,
  output logic [NUM_CHANNELS-1:0]                    mem_req_rw,
  output logic [NUM_CHANNELS-1:0][BE_W-1:0]          mem_req_byteen,
  output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0]    mem_req_size,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]    mem_req_addr,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_req_data,
  output logic [NUM_CHANNELS-1:0][TAG_OUT_WIDTH-1:0] mem_req_tag,
  input  logic [NUM_CHANNELS-1:0]                    mem_req_ready,
  input  logic [NUM_CHANNELS-1:0]                    mem_rsp_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_rsp_data,
  input  logic [NUM_CHANNELS-1:0][TAG_OUT_WIDTH-1:0] mem_rsp_tag,
  output logic [NUM_CHANNELS-1:0]                    mem_rsp_ready,
  output logic [NUM_REQS-1:0]                        rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]        rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]      rsp_tag_out,
  input  logic [NUM_REQS-1:0]                        rsp_ready_out,
  output logic                                       busy
);

  localparam int CH_BITS = $clog2(NUM_CHANNELS);
  localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);

  typedef struct packed {
    logic                     rw;
    logic [BE_W-1:0]          byteen;
    logic [SIZE_WIDTH-1:0]    size;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;

  logic [NUM_REQS-1:0][CH_W-1:0]   req_ch;
  logic [NUM_REQS-1:0][PEND_W-1:0] pending;
  logic [NUM_REQS-1:0]             elig;
  logic [NUM_REQS-1:0]             rd_fire;
  req_t [NUM_REQS-1:0]             in_req;

  logic [NUM_CHANNELS-1:0][NUM_REQS-1:0] ch_vec;
  logic [NUM_CHANNELS-1:0][NUM_REQS-1:0] ch_gnt;
  logic [NUM_CHANNELS-1:0][REQ_BITS-1:0] ch_idx;
  logic [NUM_CHANNELS-1:0]               ch_any;
  logic [NUM_CHANNELS-1:0]               ch_open;
  logic [NUM_CHANNELS-1:0]               ch_fire;
  req_t [NUM_CHANNELS-1:0]               out_q;
  logic [NUM_CHANNELS-1:0]               out_v;

  logic [NUM_CHANNELS-1:0][REQ_BITS-1:0] rsp_idx;
  logic [NUM_CHANNELS-1:0]               rsp_drop;
  logic [NUM_REQS-1:0][NUM_CHANNELS-1:0] rsp_vec;
  logic [NUM_REQS-1:0][NUM_CHANNELS-1:0] rsp_gnt;
  logic [NUM_REQS-1:0][CH_W-1:0]         rsp_sel;
  logic [NUM_REQS-1:0]                   rsp_fire;

  generate
    if (CH_BITS > 0) begin : g_ch_sel
      for (genvar r = 0; r < NUM_REQS; r++) begin : g_req
        assign req_ch[r] = req_addr_in[r][CH_SEL_LSB +: CH_BITS];
      end
    end else begin : g_ch_one
      assign req_ch = '0;
    end
  endgenerate

  always_comb begin
    in_req = '0;
    elig   = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      elig[r] = req_valid_in[r] &&
                (req_rw_in[r] || pending[r] < PEND_W'(MAX_PENDING));
      in_req[r].rw     = req_rw_in[r];
      in_req[r].byteen = req_byteen_in[r];
      in_req[r].size   = req_size_in[r];
      in_req[r].addr   = req_addr_in[r];
      in_req[r].data   = req_data_in[r];
      in_req[r].tag    = {req_tag_in[r], REQ_BITS'(r)};
    end
  end

  always_comb begin
    ch_vec = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int r = 0; r < NUM_REQS; r++) begin
        ch_vec[c][r] = elig[r] && (req_ch[r] == CH_W'(c));
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_req_arb
      vx_rr_arbiter #(.NUM_INPUTS(NUM_REQS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .valid       (ch_vec[c]),
        .fire        (ch_fire[c]),
        .grant       (ch_gnt[c]),
        .grant_idx   (ch_idx[c]),
        .grant_valid (ch_any[c])
      );
    end
  endgenerate

  assign ch_open = ~out_v | mem_req_ready;
  assign ch_fire = ch_any & ch_open;

  always_comb begin
    req_ready_in = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req_ready_in = req_ready_in | (ch_gnt[c] & {NUM_REQS{ch_open[c]}});
    end
  end

  assign rd_fire = req_ready_in & ~req_rw_in;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!reset) begin
        out_v[c] <= 1'b0;
      end else if (ch_fire[c]) begin
        out_v[c] <= 1'b1;
      end else if (mem_req_ready[c]) begin
        out_v[c] <= 1'b0;
      end
      if (ch_fire[c]) begin
        out_q[c] <= in_req[ch_idx[c]];
      end
    end
  end

  always_comb begin
    mem_req_valid = out_v;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_req_rw[c]     = out_q[c].rw;
      mem_req_byteen[c] = out_q[c].byteen;
      mem_req_size[c]   = out_q[c].size;
      mem_req_addr[c]   = out_q[c].addr;
      mem_req_data[c]   = out_q[c].data;
      mem_req_tag[c]    = out_q[c].tag;
    end
  end

  // Responses to a requester with no reads in flight are stale (pre-reset)
  always_comb begin
    rsp_vec  = '0;
    rsp_drop = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rsp_idx[c] = mem_rsp_tag[c][REQ_BITS-1:0];
      for (int r = 0; r < NUM_REQS; r++) begin
        if (mem_rsp_valid[c] && rsp_idx[c] == REQ_BITS'(r)) begin
          rsp_vec[r][c] = (pending[r] != '0);
          rsp_drop[c]   = (pending[r] == '0);
        end
      end
    end
  end

  generate
    for (genvar r = 0; r < NUM_REQS; r++) begin : g_rsp_arb
      vx_rr_arbiter #(.NUM_INPUTS(NUM_CHANNELS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .valid       (rsp_vec[r]),
        .fire        (rsp_fire[r]),
        .grant       (rsp_gnt[r]),
        .grant_idx   (rsp_sel[r]),
        .grant_valid (rsp_valid_out[r])
      );
    end
  endgenerate

  assign rsp_fire = rsp_valid_out & rsp_ready_out;

  always_comb begin
    rsp_data_out  = '0;
    rsp_tag_out   = '0;
    mem_rsp_ready = rsp_drop;
    for (int r = 0; r < NUM_REQS; r++) begin
      rsp_data_out[r] = mem_rsp_data[rsp_sel[r]];
      rsp_tag_out[r]  = mem_rsp_tag[rsp_sel[r]][TAG_OUT_WIDTH-1:REQ_BITS];
      mem_rsp_ready   = mem_rsp_ready |
                        (rsp_gnt[r] & {NUM_CHANNELS{rsp_ready_out[r]}});
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REQS; r++) begin
      if (!reset) begin
        pending[r] <= '0;
      end else if (rd_fire[r] && !rsp_fire[r]) begin
        pending[r] <= pending[r] + PEND_W'(1);
      end else if (!rd_fire[r] && rsp_fire[r]) begin
        pending[r] <= pending[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (|pending) || (|out_v);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REQS; r++) begin
        assert (!(rd_fire[r] && pending[r] == PEND_W'(MAX_PENDING)))
          else $error("read credit overflow on requester %0d", r);
        assert (!(rsp_fire[r] && pending[r] == '0))
          else $error("read credit underflow on requester %0d", r);
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        assert (!(mem_rsp_valid[c] && int'(rsp_idx[c]) >= NUM_REQS))
          else $error("response index out of range on channel %0d", c);
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_channel_arb.sv
// Directed bench: vector table for arbitration, hand sequences for
// credits, response serialisation, busy lag and mid-flight reset.
module tb_vx_mem_channel_arb;

  localparam int NR  = 4;
  localparam int NC  = 2;
  localparam int DW  = 64;
  localparam int TOW = 10;

  logic                  clk;
  logic                  reset;
  logic [NR-1:0]         req_valid_in;
  logic [NR-1:0]         req_rw_in;
  logic [NR-1:0][7:0]    req_byteen_in;
  logic [NR-1:0][5:0]    req_size_in;
  logic [NR-1:0][31:0]   req_addr_in;
  logic [NR-1:0][DW-1:0] req_data_in;
  logic [NR-1:0][7:0]    req_tag_in;
  logic [NR-1:0]         req_ready_in;
  logic [NC-1:0]          mem_req_valid;
  logic [NC-1:0]          mem_req_rw;
  logic [NC-1:0][7:0]     mem_req_byteen;
  logic [NC-1:0][5:0]     mem_req_size;
  logic [NC-1:0][31:0]    mem_req_addr;
  logic [NC-1:0][DW-1:0]  mem_req_data;
  logic [NC-1:0][TOW-1:0] mem_req_tag;
  logic [NC-1:0]          mem_req_ready;
  logic [NC-1:0]          mem_rsp_valid;
  logic [NC-1:0][DW-1:0]  mem_rsp_data;
  logic [NC-1:0][TOW-1:0] mem_rsp_tag;
  logic [NC-1:0]          mem_rsp_ready;
  logic [NR-1:0]          rsp_valid_out;
  logic [NR-1:0][DW-1:0]  rsp_data_out;
  logic [NR-1:0][7:0]     rsp_tag_out;
  logic [NR-1:0]          rsp_ready_out;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  vx_mem_channel_arb #(
    .NUM_REQS(NR), .NUM_CHANNELS(NC), .ADDR_WIDTH(32), .DATA_WIDTH(DW),
    .SIZE_WIDTH(6), .TAG_IN_WIDTH(8), .CH_SEL_LSB(6), .MAX_PENDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in),
    .req_byteen_in(req_byteen_in), .req_size_in(req_size_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_size(mem_req_size),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] v;
    logic [3:0] rw;
    logic [3:0] ch;
    logic [1:0] mrdy;
    logic [3:0] rdy;
    logic [1:0] mv;
    logic [9:0] t0;
    logic [9:0] t1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_byteen_in = '0;
    req_size_in   = '0;
    req_addr_in   = '0;
    req_data_in   = '0;
    req_tag_in    = '0;
    mem_rsp_valid = '0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
  endtask

  task automatic set_req(input int r, input logic v, input logic rw,
                         input logic [31:0] addr, input logic [7:0] tag);
    req_valid_in[r]  = v;
    req_rw_in[r]     = rw;
    req_addr_in[r]   = addr;
    req_tag_in[r]    = tag;
    req_byteen_in[r] = 8'hF0 | 8'(r);
    req_size_in[r]   = 6'(r + 1);
    req_data_in[r]   = {32'hCAFE0000 | 32'(r), 32'(tag)};
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 2'b11, 4'b0001, 2'b01, 10'h000, 10'h000};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 2'b11, 4'b0010, 2'b01, 10'h045, 10'h000};
    tbl[2]  = '{4'hF, 4'h0, 4'h0, 2'b11, 4'b0100, 2'b01, 10'h08A, 10'h000};
    tbl[3]  = '{4'hF, 4'h0, 4'h0, 2'b11, 4'b1000, 2'b01, 10'h0CF, 10'h000};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 2'b11, 4'b0001, 2'b01, 10'h010, 10'h000};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 2'b00, 4'b0000, 2'b01, 10'h010, 10'h000};
    tbl[6]  = '{4'hF, 4'h0, 4'h0, 2'b00, 4'b0000, 2'b01, 10'h010, 10'h000};
    tbl[7]  = '{4'hF, 4'h0, 4'h0, 2'b00, 4'b0000, 2'b01, 10'h010, 10'h000};
    tbl[8]  = '{4'hF, 4'hF, 4'h5, 2'b11, 4'b0011, 2'b11, 10'h061, 10'h020};
    tbl[9]  = '{4'hF, 4'hF, 4'h5, 2'b11, 4'b1100, 2'b11, 10'h0E7, 10'h0A6};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 2'b11, 4'b0000, 2'b00, 10'h000, 10'h000};
    tbl[11] = '{4'h3, 4'h0, 4'h1, 2'b11, 4'b0010, 2'b01, 10'h06D, 10'h000};

    idle();
    reset         = 1'b0;
    mem_req_ready = 2'b11;
    rsp_ready_out = '1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ready", 64'(req_ready_in), 64'h0);

    // Arbitration table: each row is one cycle, state carries across rows
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NR; r++) begin
        set_req(r, tbl[i].v[r], tbl[i].rw[r],
                tbl[i].ch[r] ? 32'h40 : 32'h0, 8'((r << 4) + i));
      end
      mem_req_ready = tbl[i].mrdy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready_in), 64'(tbl[i].rdy));
      tick();
      chk($sformatf("tbl%0d_mvalid", i), 64'(mem_req_valid), 64'(tbl[i].mv));
      if (tbl[i].mv[0])
        chk($sformatf("tbl%0d_tag0", i), 64'(mem_req_tag[0]), 64'(tbl[i].t0));
      if (tbl[i].mv[1])
        chk($sformatf("tbl%0d_tag1", i), 64'(mem_req_tag[1]), 64'(tbl[i].t1));
      if (tbl[i].rw[0])
        chk($sformatf("tbl%0d_rw", i), 64'(mem_req_rw), 64'(tbl[i].mv));
    end

    // Single read routed to channel 1 and its response back
    do_reset();
    mem_req_ready = 2'b11;
    set_req(2, 1'b1, 1'b0, 32'h40, 8'h11);
    #1;
    chk("sr_ready", 64'(req_ready_in), 64'b0100);
    tick();
    idle();
    chk("sr_mvalid", 64'(mem_req_valid), 64'b10);
    chk("sr_tag", 64'(mem_req_tag[1]), 64'h046);
    chk("sr_addr", 64'(mem_req_addr[1]), 64'h40);
    chk("sr_data", mem_req_data[1], 64'hCAFE0002_00000011);
    chk("sr_be_size", 64'({mem_req_byteen[1], mem_req_size[1]}), 64'({8'hF2, 6'd3}));
    mem_rsp_valid   = 2'b10;
    mem_rsp_tag[1]  = 10'h046;
    mem_rsp_data[1] = 64'hDEADBEEF_01234567;
    #1;
    chk("sr_rsp_valid", 64'(rsp_valid_out), 64'b0100);
    chk("sr_rsp_tag", 64'(rsp_tag_out[2]), 64'h11);
    chk("sr_rsp_data", rsp_data_out[2], 64'hDEADBEEF_01234567);
    chk("sr_rsp_ready", 64'(mem_rsp_ready), 64'b10);
    tick();
    idle();

    // Credit limit of two reads, writes bypass, no same-cycle bypass
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0, 8'h01);
    #1;
    chk("cr_first", 64'(req_ready_in[0]), 64'h1);
    tick();
    chk("cr_second", 64'(req_ready_in[0]), 64'h1);
    tick();
    chk("cr_stall", 64'(req_ready_in[0]), 64'h0);
    req_rw_in[0] = 1'b1;
    #1;
    chk("cr_write", 64'(req_ready_in[0]), 64'h1);
    tick();
    req_rw_in[0]   = 1'b0;
    mem_rsp_valid  = 2'b01;
    mem_rsp_tag[0] = 10'h3FC;
    #1;
    chk("cr_nobypass", 64'(req_ready_in[0]), 64'h0);
    chk("cr_rsp", 64'(rsp_valid_out), 64'b0001);
    tick();
    mem_rsp_valid = '0;
    #1;
    chk("cr_refire", 64'(req_ready_in[0]), 64'h1);
    tick();
    idle();

    // Two channels answering requester 1 together are serialised
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'h0, 8'h21);
    tick();
    req_addr_in[1] = 32'h40;
    tick();
    idle();
    tick();
    mem_rsp_valid  = 2'b11;
    mem_rsp_tag[0] = {8'hA0, 2'b01};
    mem_rsp_tag[1] = {8'hB0, 2'b01};
    #1;
    chk("dual_first_tag", 64'(rsp_tag_out[1]), 64'hA0);
    chk("dual_first_rdy", 64'(mem_rsp_ready), 64'b01);
    tick();
    chk("dual_second_tag", 64'(rsp_tag_out[1]), 64'hB0);
    chk("dual_second_rdy", 64'(mem_rsp_ready), 64'b10);
    tick();
    idle();

    // Read fire and response on requester 1 in the same cycle
    set_req(1, 1'b1, 1'b0, 32'h0, 8'h31);
    #1;
    chk("sim_first", 64'(req_ready_in[1]), 64'h1);
    tick();
    mem_rsp_valid  = 2'b01;
    mem_rsp_tag[0] = {8'h55, 2'b01};
    #1;
    chk("sim_both_rdy", 64'(req_ready_in[1]), 64'h1);
    chk("sim_both_rsp", 64'(rsp_valid_out[1]), 64'h1);
    tick();
    mem_rsp_valid = '0;
    #1;
    chk("sim_pend_one", 64'(req_ready_in[1]), 64'h1);
    tick();
    chk("sim_pend_full", 64'(req_ready_in[1]), 64'h0);
    idle();

    // Parallel channels and busy lag
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h00, 8'h01);
    set_req(1, 1'b1, 1'b0, 32'h40, 8'h02);
    #1;
    chk("par_ready", 64'(req_ready_in), 64'b0011);
    tick();
    idle();
    chk("par_mvalid", 64'(mem_req_valid), 64'b11);
    chk("par_busy_lag", 64'(busy), 64'h0);
    tick();
    chk("par_busy_on", 64'(busy), 64'h1);
    mem_rsp_valid  = 2'b01;
    mem_rsp_tag[0] = {8'h01, 2'b00};
    tick();
    mem_rsp_valid  = 2'b10;
    mem_rsp_tag[1] = {8'h02, 2'b01};
    #1;
    chk("par_busy_one_left", 64'(busy), 64'h1);
    tick();
    mem_rsp_valid = '0;
    chk("par_busy_tail", 64'(busy), 64'h1);
    tick();
    chk("par_busy_off", 64'(busy), 64'h0);

    // Reset with reads outstanding and requests buffered
    do_reset();
    mem_req_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, 32'h00, 8'h0A);
    set_req(1, 1'b1, 1'b0, 32'h40, 8'h0B);
    tick();
    idle();
    mem_req_ready = 2'b00;
    set_req(2, 1'b1, 1'b1, 32'h00, 8'h0C);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mr_mvalid", 64'(mem_req_valid), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    mem_rsp_valid  = 2'b01;
    mem_rsp_tag[0] = {8'h0A, 2'b00};
    #1;
    chk("mr_rsp_drop", 64'(rsp_valid_out), 64'h0);
    chk("mr_rsp_ready", 64'(mem_rsp_ready), 64'b01);
    tick();
    idle();
    mem_req_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, 32'h00, 8'h0D);
    #1;
    chk("mr_cnt_first", 64'(req_ready_in[0]), 64'h1);
    tick();
    chk("mr_cnt_second", 64'(req_ready_in[0]), 64'h1);
    tick();
    chk("mr_cnt_full", 64'(req_ready_in[0]), 64'h0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_mem_channel_arb.md
Name: vx_mem_channel_arb

Overview:
- Parametrised successor to the single-port cluster-to-memory arbiter.
- Routes NUM_REQS requester ports (clusters or L3 banks) onto NUM_CHANNELS independent memory channels, selected by address interleave.
- Per-channel round-robin request arbitration; responses returned to their requester via tag.
- Per-requester outstanding-read credit limit; busy reports in-flight traffic.

Parameters:
- NUM_REQS, 4, requester ports (>=1).
- NUM_CHANNELS, 2, memory channels (power of 2, >=1).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 512, data width; byteen width = DATA_WIDTH/8.
- SIZE_WIDTH, 6, request size field width.
- TAG_IN_WIDTH, 8, requester tag width.
- CH_SEL_LSB, 6, lowest address bit of the channel-select field.
- MAX_PENDING, 16, max outstanding reads per requester (>=1).
- Derived: REQ_BITS = max(1, clog2(NUM_REQS)); TAG_OUT_WIDTH = TAG_IN_WIDTH + REQ_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid_in  in  NUM_REQS  request valid per requester.
- req_rw_in  in  NUM_REQS  1 = write.
- req_byteen_in  in  NUM_REQS x DATA_WIDTH/8  byte enables.
- req_size_in  in  NUM_REQS x SIZE_WIDTH  size.
- req_addr_in  in  NUM_REQS x ADDR_WIDTH  address.
- req_data_in  in  NUM_REQS x DATA_WIDTH  write data.
- req_tag_in  in  NUM_REQS x TAG_IN_WIDTH  tag.
- req_ready_in  out  NUM_REQS  request accepted.
- mem_req_valid/rw/byteen/size/addr/data/tag/ready  out (ready in)  NUM_CHANNELS x field width  per-channel request; tag is TAG_OUT_WIDTH.
- mem_rsp_valid  in  NUM_CHANNELS  response valid.
- mem_rsp_data  in  NUM_CHANNELS x DATA_WIDTH  response data.
- mem_rsp_tag  in  NUM_CHANNELS x TAG_OUT_WIDTH  response tag.
- mem_rsp_ready  out  NUM_CHANNELS  response accepted.
- rsp_valid_out/data_out/tag_out  out  NUM_REQS x (1/DATA_WIDTH/TAG_IN_WIDTH)  per-requester response.
- rsp_ready_out  in  NUM_REQS  requester accepts response.
- busy  out  1  any read outstanding or any request buffered.

Behaviour:
- Reset (reset==0 at posedge): all mem_req_valid=0, rsp_valid_out=0, counters=0, round-robin pointers=0, busy=0. Reset asserted mid-transfer drops buffered requests and in-flight accounting; responses arriving after reset are discarded.
- Channel select: ch = addr[CH_SEL_LSB +: clog2(NUM_CHANNELS)]; NUM_CHANNELS==1 gives ch = 0. The address is forwarded unmodified.
- Eligibility: requester r is eligible when req_valid_in[r] is high and (rw==1 or pending[r] < MAX_PENDING).
- Arbitration: each channel grants one eligible requester targeting it per cycle, round-robin. The pointer advances to winner+1 only on a fire.
- req_ready_in[r] = granted and the channel's output register is empty or draining (mem_req_ready high).
- Output register: one-entry pipe register per channel; latency is 1 cycle from input fire to mem_req_valid. Full throughput is sustained while mem_req_ready stays high. Held stable while valid && !ready.
- Outbound tag = {req_tag_in, r[REQ_BITS-1:0]}; with NUM_REQS==1 the index bit is 0.
- Writes produce no response and do not consume credits.
- Credits: pending[r] is clog2(MAX_PENDING+1) bits.
  - +1 on a read fire; -1 on rsp fire to r; both in the same cycle leaves it unchanged.
  - A read is blocked at pending==MAX_PENDING, even if a response returns that cycle (no bypass).
  - Overflow and underflow are assertion errors.
- Response routing: r = mem_rsp_tag[REQ_BITS-1:0]; the upper bits go to rsp_tag_out.
  - Per-requester round-robin across channels whose responses target r.
  - Responses are combinational: mem_rsp_ready[c] = grant to c && rsp_ready_out[r]. No response buffering; zero-cycle latency.
  - A channel whose response index is >= NUM_REQS is an assertion error.
- busy = |pending || |mem_req_valid, registered (1-cycle lag).

Decomposition:
- vx_mem_arb_pkg: REQ_BITS/TAG_OUT_WIDTH computation functions, and a packed request struct typedef (rw, byteen, size, addr, data, tag).
- Sub-module vx_rr_arbiter (NUM_INPUTS; valid vector in; one-hot grant and index out; advances on a fire input). It is instantiated NUM_CHANNELS times for requests and NUM_REQS times for responses.

Test Plan:
- Single read: NUM_REQS=4, NUM_CHANNELS=2, r=2 reads addr 0x40, tag 0x11.
  - Required: next cycle mem_req_valid[1]=1 with tag 0x46.
  - Response tag 0x46 gives rsp_valid_out[2]=1, tag 0x11, same cycle.
- Contention: all 4 requesters read channel 0 every cycle with mem_req_ready=1.
  - Required: grants in order 0,1,2,3,0, one per cycle.
  - mem_req_ready held 0 for 3 cycles: output stable, no req_ready_in.
- Credit limit: MAX_PENDING=2, r=0 issues 3 reads with no responses.
  - Required: third stalls (req_ready_in[0]=0); a write from r=0 is still accepted.
  - One response returned: third fires the following cycle.
- Simultaneous: read fire and response on r=1 in the same cycle leaves pending[1] unchanged.
  - Two channels responding to r=1 together: serialised, channel 0 first, then channel 1.
- Parallel channels: reads to 0x00 and 0x40 from r=0 and r=1 the same cycle both fire in parallel. busy is 1 until both responses are taken, then 0 one cycle later.
- Reset: assert reset=0 while 2 reads are outstanding and a request is buffered.
  - Required next cycle: all valids 0, busy 0, counters 0.
